// File: rtl/motor_ramp_ctrl_if.sv
// Command handshake bundle between a motion sequencer and motor_ramp_ctrl.
// Pure wiring, no latency; cmd_ready is the only backpressure signal.
// Build option honoured by the consumer: MOTOR_RAMP_BRAKE_EN (adds brake port).
interface motor_ramp_ctrl_if #(
    parameter int CTR_LEN = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic [CTR_LEN-1:0] cmd_speed;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_speed,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_speed,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slews pwm compare toward a commanded direction/speed; reversals pass through zero plus dead-time. Optional brake: MOTOR_RAMP_BRAKE_EN.
// Latency: all outputs registered; first duty step lands TICK_DIV cycles after the accept edge.
// Backpressure: cmd_ready drops only during the dead-time hold (and while brake is applied).
module motor_ramp_ctrl #(
    parameter int CTR_LEN     = 8,
    parameter int STEP        = 1,
    parameter int TICK_DIV    = 1024,
    parameter int DEAD_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
`ifdef MOTOR_RAMP_BRAKE_EN
    input  logic               brake,
`endif
    motor_ramp_ctrl_if.slave   cmd,
    output logic [CTR_LEN-1:0] compare,
    output logic               direction,
    output logic               at_target
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0]      DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [CTR_LEN-1:0] STEP_C    = CTR_LEN'(STEP);

    typedef enum logic [1:0] {HOLD, RAMP, DEAD} state_t;

    state_t             state;
    logic               tgt_dir;
    logic [CTR_LEN-1:0] tgt_speed;
    logic [TW-1:0]      tick_cnt;
    logic [DW-1:0]      dead_cnt;

    logic               tick;
    logic               accept;
    logic               acc_hold;
    logic               ramp_hold;
    logic [CTR_LEN:0]   up_sum;
    logic [CTR_LEN-1:0] ramp_cmp;

    assign tick     = (tick_cnt == TICK_LAST);
    assign accept   = cmd.cmd_valid && cmd.cmd_ready;
    assign acc_hold = (compare == cmd.cmd_speed) &&
                      ((direction == cmd.cmd_dir) || (cmd.cmd_speed == '0));
    // Extra carry bit keeps a near-full-scale step from wrapping past the target.
    assign up_sum   = {1'b0, compare} + {1'b0, STEP_C};

    always_comb begin
        ramp_cmp = compare;
        if (direction != tgt_dir)
            ramp_cmp = (compare > STEP_C) ? compare - STEP_C : '0;
        else if (compare < tgt_speed)
            ramp_cmp = (up_sum > {1'b0, tgt_speed}) ? tgt_speed : up_sum[CTR_LEN-1:0];
        else if (compare > tgt_speed)
            ramp_cmp = ((compare - tgt_speed) > STEP_C) ? compare - STEP_C : tgt_speed;
    end

    assign ramp_hold = (ramp_cmp == tgt_speed) &&
                       ((direction == tgt_dir) || (tgt_speed == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            compare       <= '0;
            direction     <= 1'b0;
            tgt_dir       <= 1'b0;
            tgt_speed     <= '0;
            tick_cnt      <= '0;
            dead_cnt      <= '0;
            state         <= HOLD;
            at_target     <= 1'b1;
            cmd.cmd_ready <= 1'b1;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
`ifdef MOTOR_RAMP_BRAKE_EN
            if (brake) begin
                compare       <= '0;
                tgt_speed     <= '0;
                state         <= HOLD;
                at_target     <= 1'b1;
                cmd.cmd_ready <= 1'b0;
            end else
`endif
            begin
                cmd.cmd_ready <= 1'b1;
                if (accept) begin
                    tgt_dir   <= cmd.cmd_dir;
                    tgt_speed <= cmd.cmd_speed;
                    tick_cnt  <= '0;
                    state     <= acc_hold ? HOLD : RAMP;
                    at_target <= acc_hold;
                end else begin
                    case (state)
                        RAMP: begin
                            if (tick) begin
                                // Not in HOLD here, so compare==0 with a mismatched
                                // direction implies a non-zero target: start dead-time.
                                if ((direction != tgt_dir) && (compare == '0)) begin
                                    state         <= DEAD;
                                    dead_cnt      <= '0;
                                    cmd.cmd_ready <= 1'b0;
                                end else begin
                                    compare <= ramp_cmp;
                                    if (ramp_hold) begin
                                        state     <= HOLD;
                                        at_target <= 1'b1;
                                    end
                                end
                            end
                        end
                        DEAD: begin
                            dead_cnt <= dead_cnt + 1'b1;
                            if (dead_cnt == DEAD_LAST) begin
                                direction <= tgt_dir;
                                tick_cnt  <= '0;
                                state     <= RAMP;
                            end else begin
                                cmd.cmd_ready <= 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed vector table plus hand sequences for motor_ramp_ctrl (CTR_LEN=8, STEP=16, TICK_DIV=4, DEAD_CYCLES=3).
// Brake sequence is built only with MOTOR_RAMP_BRAKE_EN.
module tb_motor_ramp_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       brake = 1'b0;
    logic [7:0] compare;
    logic       direction;
    logic       at_target;

    int n_cmp = 0;
    int n_err = 0;

    motor_ramp_ctrl_if #(.CTR_LEN(8)) cif ();

    motor_ramp_ctrl #(
        .CTR_LEN(8), .STEP(16), .TICK_DIV(4), .DEAD_CYCLES(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MOTOR_RAMP_BRAKE_EN
        .brake     (brake),
`endif
        .cmd       (cif),
        .compare   (compare),
        .direction (direction),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       dir;
        logic [7:0] spd;
        logic [7:0] e_cmp;
        logic       e_dir;
        logic       e_at;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input logic r, input logic vl, input logic d, input logic [7:0] s,
                              input logic [7:0] ec, input logic ed, input logic ea, input logic er);
        vec_t x;
        x.rst = r; x.vld = vl; x.dir = d; x.spd = s;
        x.e_cmp = ec; x.e_dir = ed; x.e_at = ea; x.e_rdy = er;
        tbl.push_back(x);
    endfunction

    function automatic void idle(input int n, input logic [7:0] ec, input logic ed,
                                 input logic ea, input logic er);
        for (int i = 0; i < n; i++) v(1'b0, 1'b0, 1'b0, 8'd0, ec, ed, ea, er);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic vl, input logic d, input logic [7:0] s);
        rst = r; cif.cmd_valid = vl; cif.cmd_dir = d; cif.cmd_speed = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        logic prev_dir;
        drive(1'b1, 1'b0, 1'b0, 8'd0);

        // reset state
        v(1, 0, 0, 0,   0, 0, 1, 1);
        v(1, 0, 0, 0,   0, 0, 1, 1);
        // ramp up 0 -> 64 in direction 0
        v(0, 1, 0, 64,  0, 0, 0, 1);
        idle(3, 0, 0, 0, 1);  idle(4, 16, 0, 0, 1); idle(4, 32, 0, 0, 1);
        idle(4, 48, 0, 0, 1); idle(2, 64, 0, 1, 1);
        // clamp at 40, then step down to 8
        v(1, 0, 0, 0,   0, 0, 1, 1);
        v(0, 1, 0, 40,  0, 0, 0, 1);
        idle(3, 0, 0, 0, 1);  idle(4, 16, 0, 0, 1); idle(4, 32, 0, 0, 1);
        idle(2, 40, 0, 1, 1);
        v(0, 1, 0, 8,   40, 0, 0, 1);
        idle(3, 40, 0, 0, 1); idle(4, 24, 0, 0, 1); idle(2, 8, 0, 1, 1);
        // new target mid-ramp restarts the tick and is clamped
        v(1, 0, 0, 0,   0, 0, 1, 1);
        v(0, 1, 0, 64,  0, 0, 0, 1);
        idle(3, 0, 0, 0, 1);  idle(2, 16, 0, 0, 1);
        v(0, 1, 0, 24,  16, 0, 0, 1);
        idle(3, 16, 0, 0, 1); idle(2, 24, 0, 1, 1);
        // reversal 0/64 -> 1/32 through zero and dead-time
        v(1, 0, 0, 0,   0, 0, 1, 1);
        v(0, 1, 0, 64,  0, 0, 0, 1);
        idle(3, 0, 0, 0, 1);  idle(4, 16, 0, 0, 1); idle(4, 32, 0, 0, 1);
        idle(4, 48, 0, 0, 1); idle(1, 64, 0, 1, 1);
        v(0, 1, 1, 32,  64, 0, 0, 1);
        idle(3, 64, 0, 0, 1); idle(4, 48, 0, 0, 1); idle(4, 32, 0, 0, 1);
        idle(4, 16, 0, 0, 1); idle(4, 0, 0, 0, 1);
        idle(1, 0, 0, 0, 0);
        v(0, 1, 0, 200, 0, 0, 0, 0);   // offered during dead-time: must be ignored
        idle(1, 0, 0, 0, 0);
        idle(4, 0, 1, 0, 1);
        idle(4, 16, 1, 0, 1); idle(2, 32, 1, 1, 1);
        // reset mid-ramp discards the pending target
        v(0, 1, 1, 96,  32, 1, 0, 1);
        idle(2, 32, 1, 0, 1);
        v(1, 0, 0, 0,   0, 0, 1, 1);
        idle(8, 0, 0, 1, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].dir, tbl[i].spd);
            step();
            n_cmp++;
            if ({compare, direction, at_target, cif.cmd_ready} !==
                {tbl[i].e_cmp, tbl[i].e_dir, tbl[i].e_at, tbl[i].e_rdy}) begin
                n_err++;
                $display("FAIL vec[%0d]: got cmp=%0d dir=%b at=%b rdy=%b, expected cmp=%0d dir=%b at=%b rdy=%b",
                         i, compare, direction, at_target, cif.cmd_ready,
                         tbl[i].e_cmp, tbl[i].e_dir, tbl[i].e_at, tbl[i].e_rdy);
            end
        end

        // Full-scale reversal from rest: dead-time, then 16 steps with last clamped to 255.
        drive(1'b0, 1'b1, 1'b1, 8'd255);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        prev_dir = direction;
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (direction !== prev_dir && compare != 8'd0) begin
                n_err++;
                $display("FAIL dir_flip_nonzero: got compare=%0d at flip, expected 0", compare);
            end
            prev_dir = direction;
            if (at_target) begin cyc = c; break; end
        end
        chk("full_scale_cycles", cyc, 71);
        chk("full_scale_cmp", compare, 255);
        chk("full_scale_dir", direction, 1);

        // Reversal to zero speed never flips direction.
        drive(1'b0, 1'b1, 1'b0, 8'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (at_target) begin cyc = c; break; end
        end
        chk("to_zero_cycles", cyc, 64);
        chk("to_zero_cmp", compare, 0);
        chk("to_zero_dir", direction, 1);

`ifdef MOTOR_RAMP_BRAKE_EN
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        step();
        drive(1'b0, 1'b1, 1'b0, 8'd64);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        for (int c = 0; c < 12; c++) step();
        chk("brake_pre_cmp", compare, 48);
        brake = 1'b1;
        step();
        chk("brake_cmp", compare, 0);
        chk("brake_rdy", cif.cmd_ready, 0);
        chk("brake_at", at_target, 1);
        chk("brake_dir", direction, 0);
        brake = 1'b0;
        step();
        chk("brake_rel_rdy", cif.cmd_ready, 1);
        chk("brake_rel_at", at_target, 1);
        for (int c = 0; c < 5; c++) step();
        chk("brake_rel_cmp", compare, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
